fetch_stage: RTL and testbench

//  IF stage: owns the PC, issues instruction-bus requests and holds one fetched instruction in a buffer.

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage_pc_select.sv | 28 ++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: instruction-bus request/response,
// the fetch-to-decode buffer record and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [ILEN-1:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] raw_instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_select.sv
// Combinational next-PC selection for the fetch stage.
// Priority: late redirect > decode jump > sequential (+4 after a fetch) > hold.
module pc_select
  import fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_req,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_jump_taken,
  input  logic [XLEN-1:0] i_pcsrc,
  input  logic            i_advance,
  output logic [XLEN-1:0] o_pc_next
);

  always_comb begin
    o_pc_next = i_pc;
    if (i_redirect_valid) begin
      o_pc_next = i_redirect_pc;
    end else if (i_jump_taken) begin
      o_pc_next = i_pcsrc;
    end else if (i_advance) begin
      // Wraps naturally modulo 2^64.
      o_pc_next = i_pc_req + 64'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one instruction-bus request at a time and holds
// a single fetched instruction for decode; squashes responses made stale by a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] PC_INIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output fetch_data_t dataF,
  input  logic        stallD,
  input  logic        jump,
  input  logic [63:0] pcsrc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        stallF
);

  fetch_state_t r_state;
  logic [63:0]  r_pc;
  logic [63:0]  r_pc_req;
  fetch_data_t  r_buf;

  logic         w_consume;
  logic         w_buf_free;
  logic         w_jump_taken;
  logic         w_capture;
  logic [63:0]  w_pc_next;
  logic         w_unused_addr_ok;

  assign w_consume        = r_buf.valid && !stallD;
  assign w_buf_free       = !r_buf.valid || w_consume;
  assign w_jump_taken     = (r_state == S_IDLE) && w_consume && jump;
  assign w_capture        = (r_state == S_REQ) && iresp.data_ok && !redirect_valid;
  assign w_unused_addr_ok = iresp.addr_ok;

  pc_select u_pc_select (
    .i_pc             (r_pc),
    .i_pc_req         (r_pc_req),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_jump_taken     (w_jump_taken),
    .i_pcsrc          (pcsrc),
    .i_advance        (w_capture),
    .o_pc_next        (w_pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= PC_INIT;
      r_pc_req <= PC_INIT;
      r_buf    <= '0;
    end else begin
      r_pc <= w_pc_next;
      case (r_state)
        S_IDLE: begin
          // A redirect or taken jump costs one bubble: no request on this edge.
          if (redirect_valid || w_jump_taken) begin
            r_buf <= '0;
          end else if (w_buf_free) begin
            r_pc_req <= r_pc;
            r_buf    <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (iresp.data_ok) begin
            r_state <= S_IDLE;
            if (!redirect_valid) begin
              r_buf.valid     <= 1'b1;
              r_buf.pc        <= r_pc_req;
              r_buf.raw_instr <= iresp.data;
            end
          end else if (redirect_valid) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (iresp.data_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ireq       = '0;
    ireq.valid = (r_state != S_IDLE);
    ireq.addr  = r_pc_req;
  end

  assign dataF  = r_buf;
  assign stallF = (r_state != S_IDLE);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle table for steady fetch and decode stall,
// hand sequences for jump, bus latency, redirect squash, reset abort and PC wrap.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  ibus_req_t   ireq;
  ibus_resp_t  iresp = '0;
  fetch_data_t dataF;
  logic        stallD = 1'b0;
  logic        jump = 1'b0;
  logic [63:0] pcsrc = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        stallF;

  always #5 clk = ~clk;

  fetch_stage #(.PC_INIT(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .dataF          (dataF),
    .stallD         (stallD),
    .jump           (jump),
    .pcsrc          (pcsrc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stallF         (stallF)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    logic        stalld;
    logic        exp_iv;
    logic [63:0] exp_ia;
    logic        exp_fv;
    logic [63:0] exp_fpc;
  } vec_t;

  sb_t         sb_q[$];
  logic [63:0] issued[$];
  vec_t        vec[13];
  int          checks = 0;
  int          errors = 0;
  int          bus_lat = 0;
  int          bus_cnt = 0;
  bit          drop = 1'b0;
  logic        prev_valid, prev_dok, prev_reset, prev_redir;
  logic [63:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: bus model drives the response, scoreboard pushes the expected capture,
  // then after the edge the monitor checks hold/zero rules and pops the scoreboard.
  task automatic tick();
    sb_t e;
    iresp.addr_ok = ireq.valid;
    iresp.data_ok = ireq.valid && (bus_cnt == bus_lat);
    iresp.data    = ireq.valid ? mem_word(ireq.addr) : 32'h0;
    if (iresp.data_ok && !redirect_valid && !drop && !reset)
      sb_q.push_back('{pc: ireq.addr, instr: mem_word(ireq.addr)});
    prev_valid = ireq.valid;
    prev_dok   = iresp.data_ok;
    prev_reset = reset;
    prev_redir = redirect_valid;
    prev_addr  = ireq.addr;
    @(posedge clk);
    #1;
    if (prev_reset) begin
      bus_cnt = 0;
      drop    = 1'b0;
    end else if (prev_valid) begin
      if (prev_dok) begin
        bus_cnt = 0;
        drop    = 1'b0;
      end else begin
        bus_cnt++;
        if (prev_redir) drop = 1'b1;
      end
    end
    if (ireq.valid && !prev_valid) issued.push_back(ireq.addr);
    if (prev_valid && !prev_dok && !prev_reset) begin
      chk_b("hold_valid", ireq.valid, 1'b1);
      chk_w("hold_addr", ireq.addr, prev_addr);
    end
    if (!dataF.valid) begin
      chk_w("empty_pc_zero", dataF.pc, 64'h0);
      chk_w("empty_instr_zero", {32'h0, dataF.raw_instr}, 64'h0);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("capture pc=%h instr=%h (expect pc=%h instr=%h)", dataF.pc, dataF.raw_instr, e.pc, e.instr);
      chk_b("sb_valid", dataF.valid, 1'b1);
      chk_w("sb_pc", dataF.pc, e.pc);
      chk_w("sb_instr", {32'h0, dataF.raw_instr}, {32'h0, e.instr});
    end
  endtask

  task automatic reset_dut();
    reset          = 1'b1;
    stallD         = 1'b0;
    jump           = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
    issued.delete();
  endtask

  task automatic wait_issue(input int n, input int budget);
    for (int i = 0; i < budget && issued.size() < n; i++) tick();
    chk_b("issue_timeout", issued.size() >= n, 1'b1);
  endtask

  initial begin
    int n_v;
    int n_s;
    vec[0]  = '{1'b0, 1'b0, 64'h0,         1'b0, 64'h0};
    vec[1]  = '{1'b0, 1'b1, BASE,          1'b0, 64'h0};
    vec[2]  = '{1'b0, 1'b0, 64'h0,         1'b1, BASE};
    vec[3]  = '{1'b0, 1'b1, BASE + 64'h4,  1'b0, 64'h0};
    vec[4]  = '{1'b0, 1'b0, 64'h0,         1'b1, BASE + 64'h4};
    vec[5]  = '{1'b0, 1'b1, BASE + 64'h8,  1'b0, 64'h0};
    vec[6]  = '{1'b1, 1'b0, 64'h0,         1'b1, BASE + 64'h8};
    vec[7]  = '{1'b1, 1'b0, 64'h0,         1'b1, BASE + 64'h8};
    vec[8]  = '{1'b1, 1'b0, 64'h0,         1'b1, BASE + 64'h8};
    vec[9]  = '{1'b1, 1'b0, 64'h0,         1'b1, BASE + 64'h8};
    vec[10] = '{1'b1, 1'b0, 64'h0,         1'b1, BASE + 64'h8};
    vec[11] = '{1'b0, 1'b0, 64'h0,         1'b1, BASE + 64'h8};
    vec[12] = '{1'b0, 1'b1, BASE + 64'hC,  1'b0, 64'h0};

    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_b("rst_ireq_valid", ireq.valid, 1'b0);
    chk_b("rst_stallF", stallF, 1'b0);
    chk_b("rst_dataF_valid", dataF.valid, 1'b0);

    // Steady 0-wait fetch, then a 5-cycle decode stall.
    reset_dut();
    bus_lat = 0;
    for (int i = 0; i < 13; i++) begin
      stallD = vec[i].stalld;
      chk_b($sformatf("t1_ireq_valid[%0d]", i), ireq.valid, vec[i].exp_iv);
      chk_b($sformatf("t1_stallF[%0d]", i), stallF, vec[i].exp_iv);
      if (vec[i].exp_iv) chk_w($sformatf("t1_ireq_addr[%0d]", i), ireq.addr, vec[i].exp_ia);
      chk_b($sformatf("t1_dataF_valid[%0d]", i), dataF.valid, vec[i].exp_fv);
      if (vec[i].exp_fv) chk_w($sformatf("t1_dataF_pc[%0d]", i), dataF.pc, vec[i].exp_fpc);
      tick();
    end

    // Decode jump with a valid buffer.
    stallD = 1'b0;
    chk_b("t4_pre_valid", dataF.valid, 1'b1);
    chk_w("t4_pre_pc", dataF.pc, BASE + 64'hC);
    jump  = 1'b1;
    pcsrc = BASE + 64'h100;
    issued.delete();
    tick();
    jump  = 1'b0;
    pcsrc = '0;
    chk_b("t4_bubble", ireq.valid, 1'b0);
    chk_b("t4_cleared", dataF.valid, 1'b0);
    tick();
    chk_b("t4_req", ireq.valid, 1'b1);
    chk_w("t4_addr", ireq.addr, BASE + 64'h100);
    repeat (6) tick();
    wait_issue(2, 4);
    if (issued.size() >= 2) begin
      chk_w("t4_issue0", issued[0], BASE + 64'h100);
      chk_w("t4_issue1", issued[1], BASE + 64'h104);
    end
    foreach (issued[k]) chk_b("t4_no_seq_addr", issued[k] != BASE + 64'h10, 1'b1);

    // Bus response delayed 3 cycles.
    reset_dut();
    bus_lat = 3;
    n_v = 0;
    n_s = 0;
    for (int i = 0; i < 20 && !dataF.valid; i++) begin
      if (ireq.valid) n_v++;
      if (stallF) n_s++;
      tick();
    end
    chk_b("t2_done", dataF.valid, 1'b1);
    chk_w("t2_valid_cycles", 64'(n_v), 64'd4);
    chk_w("t2_stallF_cycles", 64'(n_s), 64'd4);
    chk_w("t2_pc", dataF.pc, BASE);
    chk_w("t2_instr", {32'h0, dataF.raw_instr}, {32'h0, mem_word(BASE)});

    // Late redirect while a request is outstanding; response arrives 2 cycles later.
    reset_dut();
    bus_lat = 2;
    tick();
    chk_b("t5_req", ireq.valid, 1'b1);
    issued.delete();
    redirect_valid = 1'b1;
    redirect_pc    = BASE + 64'h200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_b("t5_no_data", dataF.valid, 1'b0);
      tick();
    end
    wait_issue(1, 10);
    if (issued.size() > 0) chk_w("t5_addr", issued[0], BASE + 64'h200);

    // Reset during a request with data_ok in the same cycle.
    reset_dut();
    bus_lat = 0;
    tick();
    chk_b("t6_req", ireq.valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_b("t6_no_capture", dataF.valid, 1'b0);
    chk_b("t6_idle", ireq.valid, 1'b0);
    issued.delete();
    wait_issue(1, 10);
    if (issued.size() > 0) chk_w("t6_addr", issued[0], BASE);

    // Late redirect in IDLE clears a stalled buffer.
    reset_dut();
    bus_lat = 0;
    tick();
    tick();
    chk_b("t7_pre", dataF.valid, 1'b1);
    stallD         = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = BASE + 64'h400;
    issued.delete();
    tick();
    stallD         = 1'b0;
    redirect_valid = 1'b0;
    chk_b("t7_cleared", dataF.valid, 1'b0);
    chk_b("t7_bubble", ireq.valid, 1'b0);
    wait_issue(1, 10);
    if (issued.size() > 0) chk_w("t7_addr", issued[0], BASE + 64'h400);

    // Simultaneous jump and redirect (redirect wins), target at the top of memory to wrap.
    reset_dut();
    bus_lat = 0;
    tick();
    tick();
    chk_b("t8_pre", dataF.valid, 1'b1);
    jump           = 1'b1;
    pcsrc          = BASE + 64'h300;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    issued.delete();
    tick();
    jump           = 1'b0;
    redirect_valid = 1'b0;
    chk_b("t8_cleared", dataF.valid, 1'b0);
    wait_issue(2, 12);
    if (issued.size() >= 2) begin
      chk_w("t8_redirect_wins", issued[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk_w("t8_wrap", issued[1], 64'h0);
    end

    tick();
    chk_w("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
